// File: rtl/logic16_arbiter.sv
// logic16_arbiter
//   Shares one 16-bit bitwise logic unit (AND / OR / XOR / NOT A) between
//   N requesters. Round-robin arbitration accepts at most one request per
//   cycle. The registered result is returned on a single response channel,
//   tagged with the requester ID and subject to backpressure.
//
// Ports
//   CLK         system clock, all state on the rising edge
//   RESET_N     asynchronous active-low reset
//   REQ_VALID   [N]      per-requester request valid
//   REQ_READY   [N]      per-requester accept strobe (one-hot or zero)
//   REQ_OP      [2N]     opcode per requester: 00 AND, 01 OR, 10 XOR, 11 NOT A
//   REQ_A       [16N]    operand A per requester
//   REQ_B       [16N]    operand B per requester (ignored for NOT)
//   RSP_VALID            response valid
//   RSP_READY            response consumer ready
//   RSP_DATA    [16]     registered result
//   RSP_ID      [IDW]    requester that produced RSP_DATA
//   XFER_COUNT  [16]     completed responses, wraps silently
module logic16_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [N-1:0]      REQ_VALID,
  output logic [N-1:0]      REQ_READY,
  input  logic [2*N-1:0]    REQ_OP,
  input  logic [16*N-1:0]   REQ_A,
  input  logic [16*N-1:0]   REQ_B,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [15:0]       RSP_DATA,
  output logic [IDW-1:0]    RSP_ID,
  output logic [15:0]       XFER_COUNT
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  logic            can_accept;
  logic            grant;
  int unsigned     idx;
  logic [N-1:0]    probe;
  logic [16*N-1:0] a_shift;
  logic [16*N-1:0] b_shift;
  logic [2*N-1:0]  op_shift;
  logic [15:0]     result;

  assign can_accept = (state == IDLE) || RSP_READY;
  assign grant      = can_accept && grant_found;

  // Round-robin search starting just after the last granted requester.
  // Bits are probed with shifted one-hot masks so every index stays a
  // plain 32-bit shift amount.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    probe       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx   = (32'(last) + k) % N;
      probe = N'(1) << idx;
      if (!grant_found && |(REQ_VALID & probe)) begin
        grant_found = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  // Operand / opcode selection for the granted requester, then the logic op
  always_comb begin
    a_shift  = REQ_A  >> (32'(grant_id) * 16);
    b_shift  = REQ_B  >> (32'(grant_id) * 16);
    op_shift = REQ_OP >> (32'(grant_id) * 2);
    unique case (op_shift[1:0])
      2'b00:   result = a_shift[15:0] & b_shift[15:0];
      2'b01:   result = a_shift[15:0] | b_shift[15:0];
      2'b10:   result = a_shift[15:0] ^ b_shift[15:0];
      default: result = ~a_shift[15:0];
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (grant) state_next = HOLD;
      HOLD: if (RSP_READY && !grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    RSP_VALID = (state == HOLD);
    REQ_READY = grant ? (N'(1) << grant_id) : '0;
  end

  // Result / pointer / transfer counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RSP_DATA   <= '0;
      RSP_ID     <= '0;
      last       <= IDW'(N - 1);
      XFER_COUNT <= '0;
    end else begin
      if (grant) begin
        RSP_DATA <= result;
        RSP_ID   <= grant_id;
        last     <= grant_id;
      end
      if (state == HOLD && RSP_READY)
        XFER_COUNT <= XFER_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
module tb_logic16_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic              CLK;
  logic              RESET_N;
  logic [N-1:0]      REQ_VALID;
  logic [N-1:0]      REQ_READY;
  logic [2*N-1:0]    REQ_OP;
  logic [16*N-1:0]   REQ_A;
  logic [16*N-1:0]   REQ_B;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [15:0]       RSP_DATA;
  logic [IDW-1:0]    RSP_ID;
  logic [15:0]       XFER_COUNT;

  logic16_arbiter #(.N(N), .IDW(IDW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_ID(RSP_ID), .XFER_COUNT(XFER_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_valid;
  logic [15:0] m_data;
  int          m_id;
  int          m_last;
  int          m_count;

  // Requester-side pending requests
  logic [N-1:0] v;
  logic [1:0]   op [N];
  logic [15:0]  a  [N];
  logic [15:0]  b  [N];
  logic         rr;

  int g;
  logic [15:0] exp_seq [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Pick the pending requester closest after m_last in cyclic order
  function automatic int ref_grant();
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d = (i - m_last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_id    = 0;
    m_last  = N - 1;
    m_count = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ_VALID[i]       = v[i];
      REQ_OP[2*i +: 2]   = op[i];
      REQ_A[16*i +: 16]  = a[i];
      REQ_B[16*i +: 16]  = b[i];
    end
    RSP_READY = rr;
  endtask

  // One clock cycle: drive, check grant, clock, update model, check response
  task automatic step(output int gr);
    logic [N-1:0] exp_ready;
    drive();
    #1;
    gr = (!m_valid || rr) ? ref_grant() : -1;
    exp_ready = '0;
    if (gr >= 0) exp_ready[gr] = 1'b1;
    check("req_ready", 32'(REQ_READY), 32'(exp_ready));
    @(posedge CLK);
    #1;
    if (m_valid && rr) m_count = (m_count + 1) % 65536;
    if (gr >= 0) begin
      m_data  = ref_op(op[gr], a[gr], b[gr]);
      m_id    = gr;
      m_last  = gr;
      m_valid = 1;
      v[gr]   = 1'b0;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    check("rsp_valid", 32'(RSP_VALID), 32'(m_valid));
    check("xfer_count", 32'(XFER_COUNT), 32'(m_count));
    if (m_valid) begin
      check("rsp_data", 32'(RSP_DATA), 32'(m_data));
      check("rsp_id", 32'(RSP_ID), 32'(m_id));
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    v  = '0;
    rr = 1'b0;
    for (int i = 0; i < N; i++) begin
      op[i] = '0; a[i] = '0; b[i] = '0;
    end
    drive();
    #2;
    check("rst_valid", 32'(RSP_VALID), 32'd0);
    check("rst_data", 32'(RSP_DATA), 32'd0);
    check("rst_id", 32'(RSP_ID), 32'd0);
    check("rst_count", 32'(XFER_COUNT), 32'd0);
    check("rst_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    RESET_N = 1'b0;
    model_reset();
    do_reset();

    // 1: single requester 2, OR
    v[2] = 1'b1; op[2] = 2'b01; a[2] = 16'hF0F0; b[2] = 16'h0FF0; rr = 1'b1;
    step(g);
    check("t1_valid", 32'(RSP_VALID), 32'd1);
    check("t1_data", 32'(RSP_DATA), 32'hFFF0);
    check("t1_id", 32'(RSP_ID), 32'd2);
    step(g);
    check("t1_idle", 32'(RSP_VALID), 32'd0);
    check("t1_count", 32'(XFER_COUNT), 32'd1);

    // 2: all four requesting back to back after reset
    do_reset();
    exp_seq[0] = 16'h0034; exp_seq[1] = 16'h12FF;
    exp_seq[2] = 16'h12CB; exp_seq[3] = 16'hEDCB;
    for (int i = 0; i < N; i++) begin
      op[i] = 2'(i); a[i] = 16'h1234; b[i] = 16'h00FF;
    end
    rr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = '1;
      step(g);
      check("t2_id", 32'(RSP_ID), 32'(k % N));
      check("t2_data", 32'(RSP_DATA), 32'(exp_seq[k % N]));
    end

    // 3: backpressure while requesters 1 and 3 wait
    v = 4'b1010;
    rr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(g);
      check("t3_ready", 32'(REQ_READY), 32'd0);
      check("t3_id", 32'(RSP_ID), 32'd0);
      check("t3_data", 32'(RSP_DATA), 32'h0034);
    end
    rr = 1'b1;
    step(g);
    check("t3_id1", 32'(RSP_ID), 32'd1);
    check("t3_data1", 32'(RSP_DATA), 32'h12FF);
    step(g);
    check("t3_id3", 32'(RSP_ID), 32'd3);
    check("t3_data3", 32'(RSP_DATA), 32'hEDCB);

    // 4: NOT ignores B
    v = '0;
    for (int k = 0; k < 8; k++) begin
      int r = int'($urandom_range(0, N - 1));
      v[r] = 1'b1; op[r] = 2'b11; a[r] = 16'hAAAA; b[r] = 16'($urandom);
      step(g);
      check("t4_not", 32'(RSP_DATA), 32'h5555);
    end

    // 5: asynchronous reset while holding a response
    check("t5_hold", 32'(RSP_VALID), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t5_valid", 32'(RSP_VALID), 32'd0);
    check("t5_data", 32'(RSP_DATA), 32'd0);
    check("t5_count", 32'(XFER_COUNT), 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
    v = 4'b1001; rr = 1'b1;
    op[0] = 2'b10; a[0] = 16'h5A5A; b[0] = 16'hFFFF;
    op[3] = 2'b00; a[3] = 16'hFFFF; b[3] = 16'h1111;
    step(g);
    check("t5_first", 32'(RSP_ID), 32'd0);
    check("t5_fdata", 32'(RSP_DATA), 32'hA5A5);

    // Randomised traffic with withdrawals and random backpressure
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1; op[i] = 2'($urandom); a[i] = 16'($urandom); b[i] = 16'($urandom);
        end else if (v[i] && $urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      step(g);
    end

    // 6: transfer counter wrap
    do_reset();
    rr = 1'b1;
    op[0] = 2'b01; a[0] = 16'h0F00; b[0] = 16'h00F0;
    for (int n = 0; n < 65536; n++) begin
      v[0] = 1'b1;
      step(g);
    end
    check("t6_ffff", 32'(XFER_COUNT), 32'hFFFF);
    v = '0;
    step(g);
    check("t6_wrap", 32'(XFER_COUNT), 32'd0);
    check("t6_idle", 32'(RSP_VALID), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic16_arbiter.md
Name: logic16_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT A) between N requesters.
- Round-robin arbitration; one accepted request per cycle at full throughput.
- Result is registered and returned on a single response channel tagged with the requester ID, with backpressure.
- Sits between CPU-side helpers / DMA-style clients and the shared 16-bit logic gate datapath.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= N.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- REQ_VALID  input  N  per-requester request valid.
- REQ_READY  output  N  per-requester accept strobe, at most one bit high.
- REQ_OP  input  2*N  opcode, requester i at bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- REQ_A  input  16*N  operand A, requester i at bits [16i+15:16i].
- REQ_B  input  16*N  operand B, same packing; ignored for NOT.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumer ready.
- RSP_DATA  output  16  registered result.
- RSP_ID  output  IDW  index of the requester that produced RSP_DATA.
- XFER_COUNT  output  16  completed responses, wraps 0xFFFF->0x0000.

Behaviour:
- Clock and reset: single clock CLK; reset is asynchronous, active-low on RESET_N.
- Reset values:
  - RSP_VALID=0, RSP_DATA=0, RSP_ID=0, XFER_COUNT=0, state=IDLE.
  - Round-robin pointer LAST=N-1, so requester 0 has top priority first.
- Reset asserted mid-transaction discards any held result; no response is emitted for it.
- States:
  - IDLE: RSP_VALID=0.
  - HOLD: RSP_VALID=1, RSP_DATA/RSP_ID stable.
- Accept condition: CAN_ACCEPT = (state==IDLE) or (RSP_READY==1).
- Grant (combinational):
  - When CAN_ACCEPT, G = first i with REQ_VALID[i]=1, searching LAST+1, LAST+2, … modulo N.
  - REQ_READY = one-hot(G). REQ_READY = 0 when no request or CAN_ACCEPT=0.
  - REQ_READY never depends on a requester's own REQ_VALID beyond selection; no combinational path from RSP_DATA.
- On a grant edge:
  - RSP_DATA <= op(REQ_A[G], REQ_B[G]); RSP_ID <= G; LAST <= G; state <= HOLD.
  - Latency: accept at edge k, RSP_VALID visible after edge k.
- HOLD transitions:
  - RSP_READY=1 and no grant: state <= IDLE, XFER_COUNT += 1.
  - RSP_READY=1 with a grant in the same cycle: stay in HOLD, load new result, XFER_COUNT += 1. Back-to-back throughput is 1 per cycle.
  - RSP_READY=0: hold everything, REQ_READY=0, LAST unchanged.
- Requester rules:
  - A requester keeps REQ_VALID and operands stable until it sees its REQ_READY bit.
  - Dropping REQ_VALID before grant is legal and simply withdraws the request.
- Fairness: with all N requesting continuously and RSP_READY=1, grants rotate 0,1,…,N-1,0,…; each requester waits at most N-1 grants.
- Arithmetic:
  - Pure bitwise, no carry.
  - NOT output = ~A; B has no effect.
- XFER_COUNT increments only on a RSP_VALID & RSP_READY cycle and wraps silently.

Test Plan:
1. Reset, then requester 2 only: A=0xF0F0, B=0x0FF0, op OR -> REQ_READY=0b0100 in that cycle; next cycle RSP_VALID=1, RSP_DATA=0xFFF0, RSP_ID=2; with RSP_READY=1 -> IDLE, XFER_COUNT=1.
2. All four valid, RSP_READY=1 constantly, ops AND/OR/XOR/NOT on A=0x1234, B=0x00FF -> grants 0,1,2,3,0 on consecutive cycles; RSP_DATA sequence 0x0034, 0x12FF, 0x12CB, 0xEDCB.
3. Backpressure: response held with RSP_READY=0 for 5 cycles while requesters 1 and 3 are valid -> REQ_READY=0, RSP_DATA/RSP_ID stable; on RSP_READY=1, requester 1 is granted the same cycle, then requester 3.
4. NOT with B toggling randomly, A=0xAAAA -> RSP_DATA=0x5555 regardless of B.
5. Assert RESET_N=0 while in HOLD with RSP_VALID=1 -> outputs clear immediately (asynchronously); after release, first grant goes to requester 0 when 0 and 3 are both valid.
6. Preload with 65535 transfers (or force XFER_COUNT=0xFFFF), complete one more -> XFER_COUNT=0x0000.
